// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor.
// Contents:
//   ch_state_e  per-channel supervisor state
//   cnt_width   width needed to hold values 0..max_val (minimum 1 bit)
//   max_u       larger of two unsigned values
package pll_mon_pkg;

  typedef enum logic [2:0] {
    StRstPulse,
    StWaitLock,
    StQual,
    StLocked,
    StFail
  } ch_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_ch.sv
// One PLL channel supervisor.
// It synchronises the raw lock and qualifies it over several cycles.
// It pulses the PLL reset and retries a bounded number of times on timeout.
// It also counts lock-loss events.
// Ports:
//   clkin1            monitor clock
//   rst               synchronous active-high reset
//   lock_i            raw PLL lock, asynchronous to clkin1
//   clr_sticky_i      clears loss_sticky_o and loss_cnt_o
//   pll_rst_o         active-high reset to the PLL
//   locked_o          channel in LOCKED state
//   fail_o            retries exhausted; terminal until rst
//   loss_sticky_o     set on a loss of lock while LOCKED
//   loss_cnt_o        saturating count of loss events
//   *_nxt_o           next-state values of the matching registered outputs. The top
//                     uses them to register its summary flags with no extra latency.
module pll_lock_ch
  import pll_mon_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned LockQualCycles = 64,
  parameter int unsigned TimeoutCycles  = 10000,
  parameter int unsigned PllRstCycles   = 16,
  parameter int unsigned MaxRetry       = 3,
  parameter int unsigned CntW           = 8
) (
  input  logic            clkin1,
  input  logic            rst,
  input  logic            lock_i,
  input  logic            clr_sticky_i,
  output logic            pll_rst_o,
  output logic            locked_o,
  output logic            fail_o,
  output logic            loss_sticky_o,
  output logic [CntW-1:0] loss_cnt_o,
  output logic            locked_nxt_o,
  output logic            fail_nxt_o,
  output logic            loss_sticky_nxt_o
);

  // The timer is shared: it counts the reset pulse and then the lock-wait window.
  localparam int unsigned TmrW  = cnt_width(max_u(TimeoutCycles, PllRstCycles));
  localparam int unsigned QualW = cnt_width(LockQualCycles);
  localparam int unsigned RtyW  = cnt_width(MaxRetry);

  localparam logic [TmrW-1:0]  PulseLast   = TmrW'(PllRstCycles - 1);
  localparam logic [TmrW-1:0]  TimeoutLast = TmrW'(TimeoutCycles - 1);
  localparam logic [QualW-1:0] QualFull    = QualW'(LockQualCycles);
  localparam logic [RtyW-1:0]  RtyMax      = RtyW'(MaxRetry);
  localparam logic [CntW-1:0]  CntMax      = '1;

  logic [SyncStages-1:0] sync_q;
  logic                  lock_s;

  ch_state_e        state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [QualW-1:0] qual_q, qual_d;
  logic [RtyW-1:0]  rty_q, rty_d;
  logic             sticky_q, sticky_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             tmo;
  logic             qual_done;

  assign lock_s = sync_q[SyncStages-1];

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    qual_d    = qual_q;
    rty_d     = rty_q;
    // A clear in the same cycle as a loss event is applied before the event.
    sticky_d  = clr_sticky_i ? 1'b0 : sticky_q;
    cnt_d     = clr_sticky_i ? '0 : cnt_q;
    tmo       = 1'b0;
    qual_done = 1'b0;

    case (state_q)
      StRstPulse: begin
        if (tmr_q == PulseLast) begin
          state_d = StWaitLock;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWaitLock: begin
        tmr_d = tmr_q + 1'b1;
        tmo   = (tmr_q == TimeoutLast);
        if (lock_s) begin
          state_d = StQual;
          qual_d  = QualW'(1);
        end
      end
      StQual: begin
        tmr_d = tmr_q + 1'b1;
        if (lock_s) begin
          if (qual_q == QualFull) begin
            qual_done = 1'b1;
            state_d   = StLocked;
            qual_d    = '0;
          end else begin
            qual_d = qual_q + 1'b1;
          end
        end else begin
          state_d = StWaitLock;
          qual_d  = '0;
        end
        // Completing qualification on the timeout edge still counts as locked.
        tmo = (tmr_q == TimeoutLast) && !qual_done;
      end
      StLocked: begin
        rty_d = '0;
        if (!lock_s) begin
          sticky_d = 1'b1;
          if (cnt_d != CntMax) begin
            cnt_d = cnt_d + 1'b1;
          end
          state_d = StRstPulse;
          tmr_d   = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StFail;
      end
    endcase

    if (tmo) begin
      qual_d = '0;
      tmr_d  = '0;
      if (rty_q != RtyMax) begin
        rty_d   = rty_q + 1'b1;
        state_d = StRstPulse;
      end else begin
        state_d = StFail;
      end
    end

    pll_rst_d = (state_d == StRstPulse) || (state_d == StFail);
    locked_d  = (state_d == StLocked);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= StRstPulse;
      tmr_q     <= '0;
      qual_q    <= '0;
      rty_q     <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], lock_i};
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      qual_q    <= qual_d;
      rty_q     <= rty_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst_o         = pll_rst_q;
  assign locked_o          = locked_q;
  assign fail_o            = fail_q;
  assign loss_sticky_o     = sticky_q;
  assign loss_cnt_o        = cnt_q;
  assign locked_nxt_o      = locked_d;
  assign fail_nxt_o        = fail_d;
  assign loss_sticky_nxt_o = sticky_d;

endmodule

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL supervisor.
// It holds one independent pll_lock_ch per PLL and registers the global summary flags.
// Ports:
//   clkin1         monitor clock
//   rst            synchronous active-high reset
//   lock_in_i      raw PLL lock per channel, asynchronous to clkin1
//   clr_sticky_i   1-cycle pulse: clear loss_sticky_o and loss_cnt_o on all channels
//   pll_rst_out_o  active-high reset to each PLL
//   ch_locked_o    channel in LOCKED state
//   ch_fail_o      channel exhausted its retries
//   loss_sticky_o  per-channel lock-loss flag
//   loss_cnt_o     saturating loss counters, ch0 in [CntW-1:0]
//   all_locked_o   every channel locked
//   chk_ok_o       all locked, no loss recorded, no channel failed
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned NumCh          = 4,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned LockQualCycles = 64,
  parameter int unsigned TimeoutCycles  = 10000,
  parameter int unsigned PllRstCycles   = 16,
  parameter int unsigned MaxRetry       = 3,
  parameter int unsigned CntW           = 8
) (
  input  logic                  clkin1,
  input  logic                  rst,
  input  logic [NumCh-1:0]      lock_in_i,
  input  logic                  clr_sticky_i,
  output logic [NumCh-1:0]      pll_rst_out_o,
  output logic [NumCh-1:0]      ch_locked_o,
  output logic [NumCh-1:0]      ch_fail_o,
  output logic [NumCh-1:0]      loss_sticky_o,
  output logic [NumCh*CntW-1:0] loss_cnt_o,
  output logic                  all_locked_o,
  output logic                  chk_ok_o
);

  logic [NumCh-1:0] ch_locked_d;
  logic [NumCh-1:0] ch_fail_d;
  logic [NumCh-1:0] loss_sticky_d;
  logic             all_locked_q;
  logic             chk_ok_q;

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    pll_lock_ch #(
      .SyncStages    (SyncStages),
      .LockQualCycles(LockQualCycles),
      .TimeoutCycles (TimeoutCycles),
      .PllRstCycles  (PllRstCycles),
      .MaxRetry      (MaxRetry),
      .CntW          (CntW)
    ) u_ch (
      .clkin1           (clkin1),
      .rst              (rst),
      .lock_i           (lock_in_i[g]),
      .clr_sticky_i     (clr_sticky_i),
      .pll_rst_o        (pll_rst_out_o[g]),
      .locked_o         (ch_locked_o[g]),
      .fail_o           (ch_fail_o[g]),
      .loss_sticky_o    (loss_sticky_o[g]),
      .loss_cnt_o       (loss_cnt_o[g*CntW +: CntW]),
      .locked_nxt_o     (ch_locked_d[g]),
      .fail_nxt_o       (ch_fail_d[g]),
      .loss_sticky_nxt_o(loss_sticky_d[g])
    );
  end

  // Built from the channels' next-state values so the summary updates on the same edge.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      all_locked_q <= 1'b0;
      chk_ok_q     <= 1'b0;
    end else begin
      all_locked_q <= &ch_locked_d;
      chk_ok_q     <= (&ch_locked_d) & ~(|loss_sticky_d) & ~(|ch_fail_d);
    end
  end

  assign all_locked_o = all_locked_q;
  assign chk_ok_o     = chk_ok_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor.
// Parameters: two channels, 4-cycle qualification, 50-cycle timeout, 3-cycle reset pulse,
// two retries and 2-bit loss counters.
module tb_pll_lock_monitor;

  logic       clkin1 = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] lock_in = 2'b00;
  logic       clr_sticky = 1'b0;
  logic [1:0] pll_rst_out;
  logic [1:0] ch_locked;
  logic [1:0] ch_fail;
  logic [1:0] loss_sticky;
  logic [3:0] loss_cnt;
  logic       all_locked;
  logic       chk_ok;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned pulse_cyc = 0;

  always #5 clkin1 = ~clkin1;

  pll_lock_monitor #(
    .NumCh         (2),
    .SyncStages    (2),
    .LockQualCycles(4),
    .TimeoutCycles (50),
    .PllRstCycles  (3),
    .MaxRetry      (2),
    .CntW          (2)
  ) dut (
    .clkin1       (clkin1),
    .rst          (rst),
    .lock_in_i    (lock_in),
    .clr_sticky_i (clr_sticky),
    .pll_rst_out_o(pll_rst_out),
    .ch_locked_o  (ch_locked),
    .ch_fail_o    (ch_fail),
    .loss_sticky_o(loss_sticky),
    .loss_cnt_o   (loss_cnt),
    .all_locked_o (all_locked),
    .chk_ok_o     (chk_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] pll, input logic [1:0] lk,
                           input logic [1:0] fl, input logic [1:0] st, input logic [3:0] cnt,
                           input logic al, input logic ok);
    check_eq({tag, "_pll_rst"}, 32'(pll_rst_out), 32'(pll));
    check_eq({tag, "_locked"}, 32'(ch_locked), 32'(lk));
    check_eq({tag, "_fail"}, 32'(ch_fail), 32'(fl));
    check_eq({tag, "_sticky"}, 32'(loss_sticky), 32'(st));
    check_eq({tag, "_cnt"}, 32'(loss_cnt), 32'(cnt));
    check_eq({tag, "_all_locked"}, 32'(all_locked), 32'(al));
    check_eq({tag, "_chk_ok"}, 32'(chk_ok), 32'(ok));
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clkin1);
      #1;
    end
  endtask

  // Drop ch1 lock from LOCKED; the loss lands on the third edge, optionally with a clear.
  task automatic drop_ch1(input bit with_clr, input logic [3:0] exp_cnt);
    lock_in[1] = 1'b0;
    step(2);
    check_eq("loss_e2_locked", 32'(ch_locked), 32'h3);
    check_eq("loss_e2_pll_rst", 32'(pll_rst_out), 32'h0);
    if (with_clr) clr_sticky = 1'b1;
    step(1);
    clr_sticky = 1'b0;
    check_eq("loss_e3_locked", 32'(ch_locked), 32'h1);
    check_eq("loss_e3_pll_rst", 32'(pll_rst_out), 32'h2);
    check_eq("loss_e3_sticky", 32'(loss_sticky), 32'h2);
    check_eq("loss_e3_cnt", 32'(loss_cnt), 32'(exp_cnt));
    check_eq("loss_e3_chk_ok", 32'(chk_ok), 32'h0);
  endtask

  // Raise ch1 lock on the loss edge; it is held in reset for 3 cycles, then needs 5 more edges.
  task automatic relock_ch1();
    lock_in[1] = 1'b1;
    step(2);
    check_eq("relock_pulse_hi", 32'(pll_rst_out), 32'h2);
    step(1);
    check_eq("relock_pulse_lo", 32'(pll_rst_out), 32'h0);
    step(4);
    check_eq("relock_e7_locked", 32'(ch_locked), 32'h1);
    step(1);
    check_eq("relock_e8_locked", 32'(ch_locked), 32'h3);
    check_eq("relock_all_locked", 32'(all_locked), 32'h1);
    check_eq("relock_chk_ok", 32'(chk_ok), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with no lock, then exactly three reset-pulse cycles after release.
    rst = 1'b1;
    lock_in = 2'b00;
    step(5);
    check_all("rst", 2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    check_eq("rel1_pll_rst", 32'(pll_rst_out), 32'h3);
    step(1);
    check_eq("rel2_pll_rst", 32'(pll_rst_out), 32'h3);
    step(1);
    check_all("rel3", 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);

    // Lock rises and holds: locked exactly 7 edges later.
    lock_in = 2'b11;
    step(6);
    check_eq("lock_e6_locked", 32'(ch_locked), 32'h0);
    step(1);
    check_all("lock_e7", 2'b00, 2'b11, 2'b00, 2'b00, 4'h0, 1'b1, 1'b1);

    // Repeated ch1 losses: counter 1, 2, 3, then saturated at 3.
    drop_ch1(1'b0, 4'b0100);
    relock_ch1();
    drop_ch1(1'b0, 4'b1000);
    relock_ch1();
    drop_ch1(1'b0, 4'b1100);
    relock_ch1();
    drop_ch1(1'b0, 4'b1100);
    relock_ch1();

    // A clear coincident with a loss leaves a count of 1.
    drop_ch1(1'b1, 4'b0100);
    relock_ch1();

    // A plain clear restores a clean status.
    clr_sticky = 1'b1;
    step(1);
    clr_sticky = 1'b0;
    check_all("clr", 2'b00, 2'b11, 2'b00, 2'b00, 4'h0, 1'b1, 1'b1);

    // Reset while locked; ch1 locks steadily, ch0 sees only 1-cycle glitches and fails.
    lock_in = 2'b10;
    rst = 1'b1;
    step(1);
    check_all("rst_locked", 2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    for (int i = 1; i <= 162; i++) begin
      lock_in[0] = ((i % 3) == 0);
      step(1);
      if (i >= 4 && i <= 158 && pll_rst_out[0]) pulse_cyc++;
      if (i == 7) check_eq("ch1_lock_e7", 32'(ch_locked), 32'h0);
      if (i == 8) check_eq("ch1_lock_e8", 32'(ch_locked), 32'h2);
      if (i == 53) check_eq("retry1_pulse", 32'(pll_rst_out), 32'h1);
      if (i == 56) check_eq("retry1_end", 32'(pll_rst_out), 32'h0);
      if (i == 158) check_eq("pre_fail", 32'(ch_fail), 32'h0);
      if (i == 159) check_all("fail", 2'b01, 2'b10, 2'b01, 2'b00, 4'h0, 1'b0, 1'b0);
      if (i == 162) check_eq("fail_held", 32'(ch_fail), 32'h1);
    end
    check_eq("retry_pulse_cycles", pulse_cyc, 32'd6);

    // Reset during FAIL clears everything.
    lock_in = 2'b11;
    rst = 1'b1;
    step(1);
    check_all("rst_fail", 2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset during qualification restarts from the reset pulse.
    step(5);
    check_eq("mid_qual_locked", 32'(ch_locked), 32'h0);
    rst = 1'b1;
    step(1);
    check_all("rst_qual", 2'b11, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(2);
    check_eq("restart_pulse_hi", 32'(pll_rst_out), 32'h3);
    step(1);
    check_eq("restart_pulse_lo", 32'(pll_rst_out), 32'h0);
    step(4);
    check_eq("restart_e7_locked", 32'(ch_locked), 32'h0);
    step(1);
    check_all("restart_e8", 2'b00, 2'b11, 2'b00, 2'b00, 4'h0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
